uart_rx_os16: RTL

16x-oversampled UART receiver clocked from the 50 MHz system clock. It consumes the 16x baud square wave from the clock divider (period 326 clk50 cycles, about 153.4 kHz, so about 9585 baud) and turns it into a one-cycle sample tick. It recovers 8N1 frames from the asynchronous `rx` line and presents each byte through a valid/ready holding register to the downstream command logic.

---
 rtl/uart_rx_os16.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16 -- 16x oversampled 8N1 UART receiver with a valid/ready
// holding register on the output side.
//
// Ports:
//   clk50     in   system clock, all logic on the rising edge
//   rst       in   asynchronous active-high reset
//   baud16    in   16x baud square wave, synchronous to clk50
//   rx        in   asynchronous serial line, idle high
//   rx_ready  in   consumer takes rx_data when high together with rx_valid
//   rx_data   out  received byte, stable while rx_valid is high
//   rx_valid  out  rx_data holds an unconsumed byte
//   frame_err out  one-cycle pulse when the stop bit is sampled low
//   overrun   out  one-cycle pulse when a completed byte is dropped
//   busy      out  receiver is inside a frame (state not IDLE)
module uart_rx_os16 #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic                 baud16,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BIDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Sample-counter landmarks inside one bit period.
  localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SMP_A    = 4'd7;
  localparam logic [3:0] SMP_B    = 4'd8;
  localparam logic [3:0] SMP_C    = 4'd9;

  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e                 state_q;
  logic                   baud16_q;
  logic                   rx_s1_q;
  logic                   rx_s2_q;
  logic [3:0]             scnt_q;
  logic [BIDX_W-1:0]      bidx_q;
  logic [2:0]             smp_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
  logic                   busy_q;

  logic                   tick;
  logic [3:0]             scnt_nxt;
  logic                   vote_live;
  logic                   vote_held;
  logic                   accept;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    tick      = baud16 & ~baud16_q;
    scnt_nxt  = (scnt_q == SMP_LAST) ? '0 : scnt_q + 4'd1;
    // At the sample-9 decision tick the third vote is still in flight, so
    // it is taken straight from the synchronizer.
    vote_live = maj3(smp_q[0], smp_q[1], rx_s2_q);
    vote_held = maj3(smp_q[0], smp_q[1], smp_q[2]);
    accept    = rx_valid_q & rx_ready;
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      baud16_q    <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      scnt_q      <= '0;
      bidx_q      <= '0;
      smp_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      baud16_q    <= baud16;
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // A handshake empties the holding register; a delivery in the same
      // cycle is assigned later below and takes precedence.
      if (accept) begin
        rx_valid_q <= 1'b0;
      end

      if (tick) begin
        if (state_q == ST_IDLE) begin
          // The detecting tick is sample 0 of the start bit.
          if (!rx_s2_q) begin
            state_q <= ST_START;
            scnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end else begin
          scnt_q <= scnt_nxt;

          if (scnt_nxt == SMP_A) smp_q[0] <= rx_s2_q;
          if (scnt_nxt == SMP_B) smp_q[1] <= rx_s2_q;
          if (scnt_nxt == SMP_C) smp_q[2] <= rx_s2_q;

          case (state_q)
            ST_START: begin
              if ((scnt_nxt == SMP_C) && vote_live) begin
                // Start bit did not hold low to mid-bit: line glitch.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else if (scnt_nxt == SMP_LAST) begin
                state_q <= ST_DATA;
                bidx_q  <= '0;
              end
            end

            ST_DATA: begin
              if (scnt_nxt == SMP_LAST) begin
                shreg_q <= {vote_held, shreg_q[DATA_BITS-1:1]};
                if (bidx_q == BIDX_LAST) begin
                  state_q <= ST_STOP;
                end else begin
                  bidx_q <= bidx_q + 1'b1;
                end
              end
            end

            ST_STOP: begin
              // Decide at mid stop bit and go idle at once so a start bit
              // that immediately follows is not missed.
              if (scnt_nxt == SMP_C) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                if (vote_live) begin
                  if (!rx_valid_q || accept) begin
                    rx_data_q  <= shreg_q;
                    rx_valid_q <= 1'b1;
                  end else begin
                    overrun_q <= 1'b1;
                  end
                end else begin
                  frame_err_q <= 1'b1;
                end
              end
            end

            default: ;
          endcase
        end
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
